// File: rtl/game_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : game_if
// Purpose  : Bundles the debounced button levels, the collide inputs from the
//            position blocks and the game-flow outputs of game_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface game_if #(
    parameter int SCORE_W = 8
);
    logic               start_btn;
    logic               pause_btn;
    logic [3:0]         enemy_collide;
    logic               food_collide;
    logic               gamemenu;
    logic               gamerun;
    logic               gamepause;
    logic               game_over;
    logic               game_won;
    logic [1:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [9:0]         radius;
    logic               tick;
    logic               hit_active;

    // Sequencer side: consumes buttons/collides, drives the game flow outputs.
    modport master (
        input  start_btn, pause_btn, enemy_collide, food_collide,
        output gamemenu, gamerun, gamepause, game_over, game_won,
               lives, score, radius, tick, hit_active
    );

    // Datapath/debouncer side.
    modport slave (
        output start_btn, pause_btn, enemy_collide, food_collide,
        input  gamemenu, gamerun, gamepause, game_over, game_won,
               lives, score, radius, tick, hit_active
    );
endinterface
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_sequencer
// Purpose  : Arena game flow controller. Generates the menu/run/pause mode
//            strobes, tracks lives, score and player radius from collide
//            events, and produces the periodic game tick.
// Revision : 1.0 - initial release
// ============================================================================
module game_sequencer #(
    parameter int TICK_DIV       = 100000000,
    parameter int LIVES_INIT     = 3,
    parameter int HIT_HOLD_TICKS = 2,
    parameter int R_INIT         = 10,
    parameter int R_STEP         = 2,
    parameter int R_MAX          = 40,
    parameter int SCORE_W        = 8,
    parameter int WIN_SCORE      = 20
) (
    input  logic   clk,
    input  logic   rst_n,
    game_if.master bus
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = (HIT_HOLD_TICKS > 0) ? $clog2(HIT_HOLD_TICKS + 1) : 1;

    localparam logic [TICK_W-1:0]  C_TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0]  C_TICK_ONE   = TICK_W'(1);
    localparam logic [HOLD_W-1:0]  C_HOLD_INIT  = HOLD_W'(HIT_HOLD_TICKS);
    localparam logic [HOLD_W-1:0]  C_HOLD_ONE   = HOLD_W'(1);
    localparam logic [1:0]         C_LIVES_INIT = 2'(LIVES_INIT);
    localparam logic [SCORE_W-1:0] C_SCORE_ONE  = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] C_WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [9:0]         C_R_INIT     = 10'(R_INIT);
    localparam logic [9:0]         C_R_MAX      = 10'(R_MAX);
    localparam logic [10:0]        C_R_MAX_X    = 11'(R_MAX);
    localparam logic [10:0]        C_R_STEP_X   = 11'(R_STEP);

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_RUN   = 3'd1,
        ST_HIT   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t             state_q,      state_d;
    logic [TICK_W-1:0]  tick_cnt_q,   tick_cnt_d;
    logic [HOLD_W-1:0]  hold_q,       hold_d;
    logic [1:0]         lives_q,      lives_d;
    logic [SCORE_W-1:0] score_q,      score_d;
    logic [9:0]         radius_q,     radius_d;
    logic               game_won_q,   game_won_d;
    logic               gamemenu_q,   gamemenu_d;
    logic               gamerun_q,    gamerun_d;
    logic               gamepause_q,  gamepause_d;
    logic               game_over_q,  game_over_d;
    logic               hit_active_q, hit_active_d;
    logic               start_prev_q, start_prev_d;
    logic               pause_prev_q, pause_prev_d;
    logic [3:0]         enemy_prev_q, enemy_prev_d;
    logic               food_prev_q,  food_prev_d;

    logic               start_edge;
    logic               pause_edge;
    logic               enemy_edge;
    logic               food_edge;
    logic               tick_now;
    logic [SCORE_W-1:0] score_inc;
    logic [10:0]        radius_sum;
    logic [9:0]         radius_inc;

    // Rising-edge events; several enemy bits in one clk collapse to one hit.
    assign start_edge = bus.start_btn    & ~start_prev_q;
    assign pause_edge = bus.pause_btn    & ~pause_prev_q;
    assign food_edge  = bus.food_collide & ~food_prev_q;
    assign enemy_edge = |(bus.enemy_collide & ~enemy_prev_q);

    assign tick_now   = (tick_cnt_q == C_TICK_LAST);

    // Score saturates at all-ones; radius is clamped at R_MAX using a wide sum.
    assign score_inc  = (&score_q) ? score_q : (score_q + C_SCORE_ONE);
    assign radius_sum = {1'b0, radius_q} + C_R_STEP_X;
    assign radius_inc = (radius_sum > C_R_MAX_X) ? C_R_MAX : radius_sum[9:0];

    // Next-state and next-output computation for the game flow.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        lives_d      = lives_q;
        score_d      = score_q;
        radius_d     = radius_q;
        game_won_d   = game_won_q;
        tick_cnt_d   = tick_now ? '0 : (tick_cnt_q + C_TICK_ONE);
        start_prev_d = bus.start_btn;
        pause_prev_d = bus.pause_btn;
        enemy_prev_d = bus.enemy_collide;
        food_prev_d  = bus.food_collide;

        case (state_q)
            ST_MENU: begin
                if (start_edge) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_HIT: begin
                if (food_edge) begin
                    score_d  = score_inc;
                    radius_d = radius_inc;
                end
                // Collisions resolve before pause; a win masks a same-clk hit.
                if (food_edge && (score_inc == C_WIN)) begin
                    state_d    = ST_OVER;
                    game_won_d = 1'b1;
                end else if ((state_q == ST_RUN) && enemy_edge) begin
                    lives_d = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
                    if (lives_d == 2'd0) begin
                        state_d    = ST_OVER;
                        game_won_d = 1'b0;
                    end else begin
                        state_d = ST_HIT;
                        hold_d  = C_HOLD_INIT;
                    end
                end else if ((state_q == ST_RUN) && pause_edge) begin
                    state_d = ST_PAUSE;
                end else if ((state_q == ST_HIT) && tick_now) begin
                    hold_d = (hold_q != '0) ? (hold_q - C_HOLD_ONE) : '0;
                    if (hold_d == '0) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_edge) begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    state_d = ST_MENU;
                end
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase

        // Game variables are reloaded on entry to MENU and held there.
        if (state_d == ST_MENU) begin
            lives_d    = C_LIVES_INIT;
            score_d    = '0;
            radius_d   = C_R_INIT;
            game_won_d = 1'b0;
        end

        gamemenu_d   = (state_d == ST_MENU);
        gamerun_d    = (state_d == ST_RUN) || (state_d == ST_HIT);
        gamepause_d  = (state_d == ST_PAUSE);
        game_over_d  = (state_d == ST_OVER);
        hit_active_d = (state_d == ST_HIT);
    end

    // State, counters, registered outputs and edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_MENU;
            tick_cnt_q   <= '0;
            hold_q       <= '0;
            lives_q      <= C_LIVES_INIT;
            score_q      <= '0;
            radius_q     <= C_R_INIT;
            game_won_q   <= 1'b0;
            gamemenu_q   <= 1'b1;
            gamerun_q    <= 1'b0;
            gamepause_q  <= 1'b0;
            game_over_q  <= 1'b0;
            hit_active_q <= 1'b0;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            enemy_prev_q <= 4'd0;
            food_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            hold_q       <= hold_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            radius_q     <= radius_d;
            game_won_q   <= game_won_d;
            gamemenu_q   <= gamemenu_d;
            gamerun_q    <= gamerun_d;
            gamepause_q  <= gamepause_d;
            game_over_q  <= game_over_d;
            hit_active_q <= hit_active_d;
            start_prev_q <= start_prev_d;
            pause_prev_q <= pause_prev_d;
            enemy_prev_q <= enemy_prev_d;
            food_prev_q  <= food_prev_d;
        end
    end

    assign bus.gamemenu   = gamemenu_q;
    assign bus.gamerun    = gamerun_q;
    assign bus.gamepause  = gamepause_q;
    assign bus.game_over  = game_over_q;
    assign bus.game_won   = game_won_q;
    assign bus.lives      = lives_q;
    assign bus.score      = score_q;
    assign bus.radius     = radius_q;
    assign bus.tick       = tick_now;
    assign bus.hit_active = hit_active_q;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_sequencer
// Purpose  : Self-checking bench for game_sequencer with a behavioural model
//            of the game rules, directed scenarios and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

    localparam int TICK_DIV       = 4;
    localparam int LIVES_INIT     = 3;
    localparam int HIT_HOLD_TICKS = 2;
    localparam int R_INIT         = 10;
    localparam int R_STEP         = 2;
    localparam int R_MAX          = 40;
    localparam int SCORE_W        = 8;
    localparam int WIN_SCORE      = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    game_if #(.SCORE_W(SCORE_W)) bus ();

    game_sequencer #(
        .TICK_DIV       (TICK_DIV),
        .LIVES_INIT     (LIVES_INIT),
        .HIT_HOLD_TICKS (HIT_HOLD_TICKS),
        .R_INIT         (R_INIT),
        .R_STEP         (R_STEP),
        .R_MAX          (R_MAX),
        .SCORE_W        (SCORE_W),
        .WIN_SCORE      (WIN_SCORE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- behavioural game model ----------------
    typedef enum int {MENU, RUN, HIT, PAUSE, OVER} mode_t;
    mode_t    m_mode;
    int       m_lives, m_score, m_radius, m_hold, m_cycles;
    bit       m_won;
    bit       m_prev_s, m_prev_p, m_prev_f;
    bit [3:0] m_prev_e;

    task automatic model_reset();
        m_mode   = MENU;
        m_lives  = LIVES_INIT;
        m_score  = 0;
        m_radius = R_INIT;
        m_won    = 1'b0;
        m_hold   = 0;
        m_cycles = 0;
        m_prev_s = 0; m_prev_p = 0; m_prev_f = 0; m_prev_e = 4'd0;
    endtask

    task automatic model_clock(input logic s, input logic p, input logic [3:0] e, input logic f);
        bit tick_now, s_ev, p_ev, f_ev, e_ev;
        tick_now = ((m_cycles % TICK_DIV) == TICK_DIV - 1);
        m_cycles++;
        s_ev = s && !m_prev_s;
        p_ev = p && !m_prev_p;
        f_ev = f && !m_prev_f;
        e_ev = ((e & ~m_prev_e) != 4'd0);
        m_prev_s = s; m_prev_p = p; m_prev_f = f; m_prev_e = e;
        case (m_mode)
            MENU:  if (s_ev) m_mode = RUN;
            PAUSE: if (p_ev) m_mode = RUN;
            OVER:  if (s_ev) m_mode = MENU;
            default: begin
                if (f_ev) begin
                    m_score  = (m_score < 255) ? m_score + 1 : 255;
                    m_radius = (m_radius + R_STEP > R_MAX) ? R_MAX : m_radius + R_STEP;
                end
                if (f_ev && m_score == WIN_SCORE) begin
                    m_mode = OVER; m_won = 1'b1;
                end else if (m_mode == RUN && e_ev) begin
                    if (m_lives > 0) m_lives--;
                    if (m_lives == 0) begin m_mode = OVER; m_won = 1'b0; end
                    else begin m_mode = HIT; m_hold = HIT_HOLD_TICKS; end
                end else if (m_mode == RUN && p_ev) begin
                    m_mode = PAUSE;
                end else if (m_mode == HIT && tick_now) begin
                    m_hold--;
                    if (m_hold <= 0) m_mode = RUN;
                end
            end
        endcase
        if (m_mode == MENU) begin
            m_lives = LIVES_INIT; m_score = 0; m_radius = R_INIT; m_won = 1'b0;
        end
    endtask

    function automatic logic [26:0] exp_vec();
        return {(m_mode == MENU), (m_mode == RUN || m_mode == HIT), (m_mode == PAUSE),
                (m_mode == OVER), m_won, (m_mode == HIT),
                ((m_cycles % TICK_DIV) == TICK_DIV - 1),
                2'(m_lives), 8'(m_score), 10'(m_radius)};
    endfunction

    function automatic logic [26:0] dut_vec();
        return {bus.gamemenu, bus.gamerun, bus.gamepause, bus.game_over, bus.game_won,
                bus.hit_active, bus.tick, bus.lives, bus.score, bus.radius};
    endfunction

    // One clock: drive inputs, take the edge, advance the model, settle.
    task automatic step(input logic s, input logic p, input logic [3:0] e, input logic f);
        bus.start_btn     = s;
        bus.pause_btn     = p;
        bus.enemy_collide = e;
        bus.food_collide  = f;
        @(posedge clk);
        model_clock(s, p, e, f);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_vec: got %h expected %h", dut_vec(), exp_vec());
        else n_pass++;
        n_checks++;
        if (bus.gamemenu !== 1'b1 || bus.lives !== 2'd3 || bus.radius !== 10'd10 || bus.score !== 8'd0)
            $display("FAIL reset_values: menu=%b lives=%0d radius=%0d score=%0d expected 1/3/10/0",
                     bus.gamemenu, bus.lives, bus.radius, bus.score);
        else n_pass++;
        step(0, 0, 4'd0, 0);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_idle: got %h expected %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_start();
        int ticks = 0;
        step(1, 0, 4'd0, 0);
        n_checks++;
        if (bus.gamemenu !== 1'b0 || bus.gamerun !== 1'b1 || bus.lives !== 2'd3 || bus.radius !== 10'd10)
            $display("FAIL start_run: menu=%b run=%b lives=%0d radius=%0d expected 0/1/3/10",
                     bus.gamemenu, bus.gamerun, bus.lives, bus.radius);
        else n_pass++;
        step(0, 0, 4'd0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 4'd0, 0);
            if (bus.tick === 1'b1) ticks++;
            n_checks++;
            if (bus.tick !== exp_vec()[20]) $display("FAIL tick_phase: got %b expected %b", bus.tick, exp_vec()[20]);
            else n_pass++;
        end
        n_checks++;
        if (ticks != 2) $display("FAIL tick_count: got %0d expected 2", ticks);
        else n_pass++;
    endtask

    task automatic test_food_win();
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 4'd0, 1);
            n_checks++;
            if (bus.score !== 8'(k) || bus.radius !== 10'(R_INIT + R_STEP * k))
                $display("FAIL food_%0d: score=%0d radius=%0d expected %0d/%0d",
                         k, bus.score, bus.radius, k, R_INIT + R_STEP * k);
            else n_pass++;
            step(0, 0, 4'd0, 0);
            repeat ($urandom_range(0, 2)) step(0, 0, 4'd0, 0);
        end
        n_checks++;
        if (bus.game_over !== 1'b1 || bus.game_won !== 1'b1 || bus.gamemenu !== 1'b0 ||
            bus.gamerun !== 1'b0 || bus.gamepause !== 1'b0)
            $display("FAIL win_over: over=%b won=%b strobes=%b%b%b expected 1/1/000",
                     bus.game_over, bus.game_won, bus.gamemenu, bus.gamerun, bus.gamepause);
        else n_pass++;
    endtask

    task automatic wait_hit_clear(input string tag);
        for (int i = 0; i < 20 && bus.hit_active === 1'b1; i++) step(0, 0, 4'd0, 0);
        n_checks++;
        if (bus.hit_active !== 1'b0 || dut_vec() !== exp_vec())
            $display("FAIL %s_hit_clear: got %h expected %h", tag, dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_lives_out();
        step(1, 0, 4'd0, 0); step(0, 0, 4'd0, 0);   // OVER -> MENU
        step(1, 0, 4'd0, 0); step(0, 0, 4'd0, 0);   // MENU -> RUN
        for (int k = 2; k >= 0; k--) begin
            step(0, 0, 4'($urandom_range(1, 15)), 0);
            n_checks++;
            if (bus.lives !== 2'(k)) $display("FAIL lives_%0d: got %0d expected %0d", k, bus.lives, k);
            else n_pass++;
            step(0, 0, 4'd0, 0);
            if (k != 0) wait_hit_clear("lives");
        end
        n_checks++;
        if (bus.game_over !== 1'b1 || bus.game_won !== 1'b0)
            $display("FAIL lose_over: over=%b won=%b expected 1/0", bus.game_over, bus.game_won);
        else n_pass++;
        step(1, 0, 4'd0, 0); step(0, 0, 4'd0, 0);
        n_checks++;
        if (bus.gamemenu !== 1'b1 || bus.lives !== 2'd3 || bus.score !== 8'd0 || bus.game_over !== 1'b0)
            $display("FAIL back_to_menu: menu=%b lives=%0d score=%0d over=%b expected 1/3/0/0",
                     bus.gamemenu, bus.lives, bus.score, bus.game_over);
        else n_pass++;
    endtask

    task automatic test_enemy_hit();
        step(1, 0, 4'd0, 0); step(0, 0, 4'd0, 0);
        step(0, 0, 4'b0101, 0);
        n_checks++;
        if (bus.lives !== 2'd2 || bus.hit_active !== 1'b1)
            $display("FAIL hit_enter: lives=%0d hit=%b expected 2/1", bus.lives, bus.hit_active);
        else n_pass++;
        step(0, 0, 4'd0, 0);
        step(0, 0, 4'b1010, 0);
        n_checks++;
        if (bus.lives !== 2'd2 || bus.hit_active !== 1'b1)
            $display("FAIL hit_ignore: lives=%0d hit=%b expected 2/1", bus.lives, bus.hit_active);
        else n_pass++;
        step(0, 0, 4'd0, 0);
        wait_hit_clear("enemy");
        n_checks++;
        if (bus.gamerun !== 1'b1) $display("FAIL hit_exit_run: run=%b expected 1", bus.gamerun);
        else n_pass++;
    endtask

    task automatic test_pause();
        int sc = m_score;
        step(0, 1, 4'd0, 0);
        n_checks++;
        if (bus.gamepause !== 1'b1 || bus.gamerun !== 1'b0)
            $display("FAIL pause_enter: pause=%b run=%b expected 1/0", bus.gamepause, bus.gamerun);
        else n_pass++;
        step(0, 0, 4'd0, 0);
        step(0, 0, 4'd0, 1);
        n_checks++;
        if (bus.score !== 8'(sc)) $display("FAIL pause_food: score=%0d expected %0d", bus.score, sc);
        else n_pass++;
        step(0, 0, 4'd0, 0);
        step(0, 1, 4'd0, 0);
        n_checks++;
        if (bus.gamerun !== 1'b1 || bus.gamepause !== 1'b0)
            $display("FAIL pause_exit: run=%b pause=%b expected 1/0", bus.gamerun, bus.gamepause);
        else n_pass++;
        step(0, 0, 4'd0, 0);
    endtask

    task automatic test_async_reset();
        step(0, 0, 4'b0001, 0);
        n_checks++;
        if (bus.hit_active !== 1'b1) $display("FAIL areset_pre_hit: hit=%b expected 1", bus.hit_active);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.gamemenu !== 1'b1 || bus.lives !== 2'd3 || bus.hit_active !== 1'b0 || bus.gamerun !== 1'b0)
            $display("FAIL areset_now: menu=%b lives=%0d hit=%b run=%b expected 1/3/0/0",
                     bus.gamemenu, bus.lives, bus.hit_active, bus.gamerun);
        else n_pass++;
        bus.enemy_collide = 4'd0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 4'd0, 0);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL areset_after: got %h expected %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        logic s = 0, p = 0, f = 0;
        logic [3:0] e = 4'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                s = ($urandom_range(0, 99) < 6);
                p = ($urandom_range(0, 99) < 8);
                f = ($urandom_range(0, 99) < 15);
                e = ($urandom_range(0, 99) < 12) ? 4'($urandom_range(1, 15)) : 4'd0;
            end
            step(s, p, e, f);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random_%0d: got %h expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.start_btn     = 1'b0;
        bus.pause_btn     = 1'b0;
        bus.enemy_collide = 4'd0;
        bus.food_collide  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_start();
        test_food_win();
        test_lives_out();
        test_enemy_hit();
        test_pause();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game flow controller for the arena.
- Drives the gamemenu/gamerun/gamepause mode strobes consumed by the four enemy position blocks and the food position block.
- Consumes their collide outputs to maintain lives, score and player radius (fed back as aR), and generates a game tick.
- Sits between the button debouncers and the position/VGA datapath.

Parameters:
TICK_DIV, 100000000, clk cycles per game tick; tick period matches the 1 s position update
LIVES_INIT, 3, lives loaded in MENU (1..3)
HIT_HOLD_TICKS, 2, ticks of invulnerability after an enemy hit
R_INIT, 10, player radius loaded in MENU
R_STEP, 2, radius increment per food eaten
R_MAX, 40, radius saturation value
SCORE_W, 8, score width
WIN_SCORE, 20, score at which the game ends as a win

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_btn  in  1  debounced, synchronised start level
pause_btn  in  1  debounced, synchronised pause level
enemy_collide  in  4  collide outputs of enemies 1..4 (bit0 = enemy 1)
food_collide  in  1  collide output of the food block
gamemenu  out  1  menu mode strobe
gamerun  out  1  run mode strobe
gamepause  out  1  pause mode strobe
game_over  out  1  high in OVER
game_won  out  1  high in OVER when ended by WIN_SCORE
lives  out  2  remaining lives
score  out  SCORE_W  food count
radius  out  10  player radius, drives aR of all position blocks
tick  out  1  one-clk pulse every TICK_DIV clks
hit_active  out  1  high in HIT (VGA blinks the player)

Behaviour:
- Reset (async, rst_n=0): state MENU; gamemenu=1; gamerun=0; gamepause=0; game_over=0; game_won=0; lives=LIVES_INIT; score=0; radius=R_INIT; tick=0; tick counter=0; hold counter=0; all edge-detect registers=0.
- Edge detection: start_btn, pause_btn, enemy_collide[3:0] and food_collide are registered every clk. An event is a rising edge (cur=1, prev=0). Levels held high never retrigger.
- Tick: free-running counter 0..TICK_DIV-1, wraps to 0. tick=1 for exactly the clk where count==TICK_DIV-1. Runs in all states.
- States and mode strobes (all registered, exactly one high or none):
  - MENU: gamemenu=1. lives, score, radius, game_won are held at their init values every clk. Start edge -> RUN.
  - RUN: gamerun=1.
    - Pause edge -> PAUSE.
    - Food edge -> score+1 (saturating at all-ones) and radius=min(radius+R_STEP, R_MAX).
    - If the new score == WIN_SCORE -> OVER with game_won=1.
    - Otherwise, any enemy edge (one or more bits, counted as a single hit) -> lives-1. If the new lives == 0 -> OVER with game_won=0; else -> HIT with hold counter=HIT_HOLD_TICKS.
    - Start edge is ignored.
  - HIT: gamerun=1 and hit_active=1.
    - Enemy edges are ignored. Food edges are processed as in RUN, including the win exit.
    - Each tick decrements the hold counter. The tick that reaches 0 returns to RUN on the next clk.
    - Pause edge is ignored.
  - PAUSE: gamepause=1. Pause edge -> RUN. Collide and start edges are ignored. lives, score and radius are frozen.
  - OVER: all three strobes 0, so the position blocks freeze. game_over=1. Start edge -> MENU. All other inputs are ignored.
- Simultaneous events in the same clk:
  - Pause edge + food/enemy edge in RUN: the collisions are applied first. Any resulting OVER/HIT transition wins over pause; otherwise the next state is PAUSE.
  - Food win + enemy edge: win has priority, and lives are not decremented.
- Widths: lives is unsigned and never underflows. radius compare is 10-bit unsigned. R_MAX must be ≤ 1023.
- State updates take effect on the clk after the triggering edge, giving 1-clk latency from input edge to strobe/counter change.

Test Plan:
TICK_DIV=4, HIT_HOLD_TICKS=2, WIN_SCORE=3, LIVES_INIT=3.
- Reset then start pulse -> gamemenu=0, gamerun=1 one clk after the edge; score=0, lives=3, radius=10; tick high on every 4th clk.
- In RUN, three separate food_collide pulses -> score 1, 2, 3 and radius 12, 14, 16; after the third, game_over=1, game_won=1, all strobes 0.
- In RUN, enemy_collide=4'b0101 pulse -> lives=2, hit_active=1. A further enemy pulse during HIT leaves lives=2. hit_active clears and gamerun stays 1 after the 2nd tick.
- Three enemy hits spaced beyond the hold window -> lives 2, 1, 0; game_over=1, game_won=0. A start pulse then returns to MENU with lives=3, score=0.
- Pause pulse in RUN -> gamepause=1, gamerun=0. A food pulse while paused leaves score unchanged. A second pause pulse -> RUN.
- Assert rst_n=0 mid-HIT, asynchronously between clk edges -> outputs immediately at reset values (gamemenu=1, lives=3, hit_active=0).
